alu_arbiter: RTL and testbench

//  Shares the single-cycle 32-bit ALU between two requesters (req0, req1) using

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// One operation in flight: accept, execute for a fixed latency, return result.
module alu_arbiter #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned OP_LAT  = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [31:0] req0_data1_i,
   input  logic [31:0] req0_data2_i,
   input  logic [3:0]  req0_ctrl_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [31:0] req1_data1_i,
   input  logic [31:0] req1_data2_i,
   input  logic [3:0]  req1_ctrl_i,
   output logic [31:0] alu_data1_o,
   output logic [31:0] alu_data2_o,
   output logic [3:0]  alu_ctrl_o,
   input  logic [31:0] alu_data_i,
   input  logic        alu_zero_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_zero_o,
   output logic        busy_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CTRL_NOOP = 4'b1011;
   localparam logic [CW-1:0] CTRL_MUL  = 4'b0101;
   localparam logic [CW-1:0] CTRL_RSVD = 4'b1100;
   localparam logic [CW-1:0] MUL_CNT   = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] OP_CNT    = CW'(OP_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic [CW-1:0] ctrl_q, ctrl_d, cnt_q, cnt_d;
   logic          id_q, id_d, last_q, last_d;
   logic          zero_q, zero_d;
   logic          rsp_valid_q, rsp_valid_d, busy_q, busy_d;

   logic          grant, grant_vld;
   logic [DW-1:0] sel_d1, sel_d2;
   logic [CW-1:0] sel_raw, sel_ctrl;

   // Pick the winner: sole valid requester, or the one not granted last on a tie.
   always_comb begin
      grant_vld = req0_valid_i | req1_valid_i;
      if (req0_valid_i && req1_valid_i) grant = ~last_q;
      else                              grant = req1_valid_i;
      sel_d1   = grant ? req1_data1_i : req0_data1_i;
      sel_d2   = grant ? req1_data2_i : req0_data2_i;
      sel_raw  = grant ? req1_ctrl_i  : req0_ctrl_i;
      sel_ctrl = (sel_raw >= CTRL_RSVD) ? CTRL_NOOP : sel_raw;
   end

   assign req0_ready_o = (state_q == S_IDLE) & req0_valid_i & ~grant;
   assign req1_ready_o = (state_q == S_IDLE) & req1_valid_i &  grant;

   // Next-state and datapath update; every register holds by default.
   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      ctrl_d      = ctrl_q;
      cnt_d       = cnt_q;
      id_d        = id_q;
      last_d      = last_q;
      rsp_data_d  = rsp_data_q;
      zero_d      = zero_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               state_d = S_EXEC;
               op1_d   = sel_d1;
               op2_d   = sel_d2;
               ctrl_d  = sel_ctrl;
               id_d    = grant;
               last_d  = grant;
               cnt_d   = (sel_ctrl == CTRL_MUL) ? MUL_CNT : OP_CNT;
               busy_d  = 1'b1;
            end
         end
         S_EXEC: begin
            if (cnt_q != CW'(0)) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               rsp_data_d  = alu_data_i;
               zero_d      = alu_zero_i;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               ctrl_d      = CTRL_NOOP;
               op1_d       = '0;
               op2_d       = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any operation in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         op1_q       <= '0;
         op2_q       <= '0;
         ctrl_q      <= CTRL_NOOP;
         cnt_q       <= '0;
         id_q        <= 1'b0;
         last_q      <= 1'b1;
         rsp_data_q  <= '0;
         zero_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         ctrl_q      <= ctrl_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         last_q      <= last_d;
         rsp_data_q  <= rsp_data_d;
         zero_q      <= zero_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign alu_data1_o = op1_q;
   assign alu_data2_o = op2_q;
   assign alu_ctrl_o  = ctrl_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = id_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_zero_o  = zero_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-timeline reference model.
module tb_alu_arbiter;

   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned OP_LAT  = 1;
   localparam logic [3:0] NOOP = 4'b1011;
   localparam logic [3:0] ADD  = 4'b0011;
   localparam logic [3:0] SUB  = 4'b0100;
   localparam logic [3:0] MUL  = 4'b0101;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
   logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
   logic [3:0]  req0_ctrl_i, req1_ctrl_i;
   logic [31:0] alu_data1_o, alu_data2_o, alu_data_i, rsp_data_o;
   logic [3:0]  alu_ctrl_o;
   logic        alu_zero_i, rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   alu_arbiter #(.MUL_LAT(MUL_LAT), .OP_LAT(OP_LAT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
      .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
      .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
      .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .busy_o(busy_o)
   );

   // Behavioural shared ALU.
   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a ^ b;
         4'b0011: return a + b;
         4'b0100: return a - b;
         4'b0101: return a * b;
         4'b0110: return {31'b0, $signed(a) < $signed(b)};
         default: return 32'h0;
      endcase
   endfunction

   always_comb begin
      alu_data_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);
      alu_zero_i = (alu_data_i == 32'h0);
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Reference model: at most one op outstanding, response due at grant cycle + 1 + latency.
   int          cyc = 0;
   bit          m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0;
   logic [31:0] m_a, m_b;
   logic [3:0]  m_ctrl;
   int          m_rsp_at = 0, m_grant_cyc = 0;
   bit          granted0 = 1'b0, granted1 = 1'b0;
   // Observations for directed checks.
   int          obs_lat = -1;
   logic [31:0] obs_data;
   logic        obs_zero, obs_id, obs_r0, obs_r1, prev_v = 1'b0;
   logic [3:0]  obs_exec_ctrl;
   logic        hs_id[$];
   logic [31:0] hs_data[$];
   logic        hs_zero[$];

   task automatic model_cycle();
      bit g, gok, rv, v0, v1;
      logic [3:0]  raw;
      logic [31:0] exp_data;
      int          lat;
      v0 = req0_valid_i;
      v1 = req1_valid_i;
      obs_r0 = req0_ready_o;
      obs_r1 = req1_ready_o;
      if (!rst_i) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         prev_v = 1'b0;
         chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
         chk1("rst_rsp_id", rsp_id_o, 1'b0);
         chk32("rst_rsp_data", rsp_data_o, 32'h0);
         chk1("rst_rsp_zero", rsp_zero_o, 1'b0);
         chk1("rst_busy", busy_o, 1'b0);
         chk1("rst_ready0", req0_ready_o, 1'b0);
         chk1("rst_ready1", req1_ready_o, 1'b0);
         chk32("rst_alu_ctrl", 32'(alu_ctrl_o), 32'(NOOP));
         chk32("rst_alu_d1", alu_data1_o, 32'h0);
         chk32("rst_alu_d2", alu_data2_o, 32'h0);
         return;
      end
      gok = !m_busy && (v0 || v1);
      g   = (v0 && v1) ? !m_last : v1;
      rv  = m_busy && (cyc >= m_rsp_at);
      chk1("ready0", req0_ready_o, gok && !g);
      chk1("ready1", req1_ready_o, gok && g);
      chk1("busy", busy_o, m_busy);
      chk1("rsp_valid", rsp_valid_o, rv);
      chk32("alu_ctrl", 32'(alu_ctrl_o), 32'(m_busy ? m_ctrl : NOOP));
      chk32("alu_d1", alu_data1_o, m_busy ? m_a : 32'h0);
      chk32("alu_d2", alu_data2_o, m_busy ? m_b : 32'h0);
      if (rv) begin
         exp_data = alu_fn(m_ctrl, m_a, m_b);
         chk1("rsp_id", rsp_id_o, m_id);
         chk32("rsp_data", rsp_data_o, exp_data);
         chk1("rsp_zero", rsp_zero_o, exp_data == 32'h0);
      end
      if (busy_o && !rsp_valid_o) obs_exec_ctrl = alu_ctrl_o;
      if (rsp_valid_o && !prev_v) begin
         obs_lat  = cyc - m_grant_cyc;
         obs_data = rsp_data_o;
         obs_zero = rsp_zero_o;
         obs_id   = rsp_id_o;
      end
      prev_v = rsp_valid_o;
      if (rsp_valid_o && rsp_ready_i) begin
         hs_id.push_back(rsp_id_o);
         hs_data.push_back(rsp_data_o);
         hs_zero.push_back(rsp_zero_o);
      end
      if (gok) begin
         raw         = g ? req1_ctrl_i : req0_ctrl_i;
         m_busy      = 1'b1;
         m_id        = g;
         m_last      = g;
         m_a         = g ? req1_data1_i : req0_data1_i;
         m_b         = g ? req1_data2_i : req0_data2_i;
         m_ctrl      = (raw >= 4'd12) ? NOOP : raw;
         lat         = (m_ctrl == MUL) ? int'(MUL_LAT) : int'(OP_LAT);
         m_grant_cyc = cyc;
         m_rsp_at    = cyc + 1 + lat;
         if (g) granted1 = 1'b1;
         else   granted0 = 1'b1;
      end else if (rv && rsp_ready_i) begin
         m_busy = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      model_cycle();
      @(posedge clk_i);
      cyc++;
      #1;
   endtask

   task automatic set_req(input int n, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] c);
      if (n == 0) begin
         req0_valid_i = v; req0_data1_i = a; req0_data2_i = b; req0_ctrl_i = c;
         granted0 = 1'b0;
      end else begin
         req1_valid_i = v; req1_data1_i = a; req1_data2_i = b; req1_ctrl_i = c;
         granted1 = 1'b0;
      end
   endtask

   function automatic logic [31:0] rnd_operand();
      if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
      return $urandom();
   endfunction

   initial begin
      rst_i = 1'b0;
      rsp_ready_i = 1'b0;
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) tick();
      rst_i = 1'b1;

      // ADD from req0 alone.
      rsp_ready_i = 1'b1;
      set_req(0, 1'b1, 32'd5, 32'd7, ADD);
      tick();
      chk1("t1_ready", obs_r0, 1'b1);
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (6) tick();
      chk32("t1_lat", 32'(obs_lat), 32'd2);
      chk32("t1_data", obs_data, 32'd12);
      chk1("t1_zero", obs_zero, 1'b0);
      chk1("t1_id", obs_id, 1'b0);

      // MUL from req1.
      set_req(1, 1'b1, 32'hFFFF_FFFD, 32'd4, MUL);
      tick();
      chk1("t2_ready", obs_r1, 1'b1);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (8) tick();
      chk32("t2_lat", 32'(obs_lat), 32'd4);
      chk32("t2_data", obs_data, 32'hFFFF_FFF4);
      chk1("t2_id", obs_id, 1'b1);

      // Both requesters valid continuously: grants alternate.
      hs_id.delete(); hs_data.delete(); hs_zero.delete();
      set_req(0, 1'b1, 32'd9, 32'd9, SUB);
      set_req(1, 1'b1, 32'd9, 32'd9, SUB);
      repeat (24) tick();
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (6) tick();
      chk1("t3_count", hs_id.size() >= 6, 1'b1);
      foreach (hs_id[i]) begin
         chk1("t3_id", hs_id[i], 1'(i % 2));
         chk32("t3_data", hs_data[i], 32'h0);
         chk1("t3_zero", hs_zero[i], 1'b1);
      end

      // Response back-pressure: outputs hold, nothing else accepted.
      rsp_ready_i = 1'b0;
      set_req(0, 1'b1, 32'd1, 32'd1, ADD);
      tick();
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b1, 32'd2, 32'd3, ADD);
      repeat (2) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("t4_ready1", obs_r1, 1'b0);
         chk1("t4_rsp_valid", rsp_valid_o, 1'b1);
         chk32("t4_rsp_data", rsp_data_o, 32'd2);
      end
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 10 && !granted1; i++) tick();
      chk1("t4_req1_served", granted1, 1'b1);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (6) tick();

      // Reset during MUL execution drops the op; round-robin restarts at req0.
      set_req(1, 1'b1, 32'd6, 32'd7, MUL);
      tick();
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      #2 rst_i = 1'b0;
      #1;
      chk1("t5_rsp_valid", rsp_valid_o, 1'b0);
      chk32("t5_alu_ctrl", 32'(alu_ctrl_o), 32'(NOOP));
      chk1("t5_busy", busy_o, 1'b0);
      tick();
      rst_i = 1'b1;
      set_req(0, 1'b1, 32'd1, 32'd2, ADD);
      set_req(1, 1'b1, 32'd3, 32'd4, ADD);
      tick();
      chk1("t5_tie0", obs_r0, 1'b1);
      chk1("t5_tie1", obs_r1, 1'b0);
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (5) tick();

      // Reserved control code is executed as NoOp.
      set_req(0, 1'b1, 32'd1, 32'd2, 4'b1111);
      tick();
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (5) tick();
      chk32("t6_ctrl", 32'(obs_exec_ctrl), 32'(NOOP));
      chk32("t6_data", obs_data, 32'h0);
      chk1("t6_zero", obs_zero, 1'b1);

      // Random traffic: each requester holds its op until the model grants it.
      for (int n = 0; n < 400; n++) begin
         if (!req0_valid_i && $urandom_range(0, 1) == 1)
            set_req(0, 1'b1, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
         if (!req1_valid_i && $urandom_range(0, 1) == 1)
            set_req(1, 1'b1, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         tick();
         if (granted0) set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
         if (granted1) set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      rsp_ready_i = 1'b1;
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
